// File: rtl/core_mem_responder.sv
// Data-memory responder for the core memory port: local word array, programmable access latency,
// 4-phase ready handshake, and a side-load port for preloading while idle.
module core_mem_responder #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        enable_M,
  input  logic [ADDR_W-1:0] addr_M,
  input  logic [DATA_W-1:0] wr_data_M,
  output logic [DATA_W-1:0] rd_data_M,
  output logic              ready_M,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              busy,
  output logic              err
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_V  = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              op_wr;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              addr_ok;
  logic              load_ok;
  logic              commit;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_wdat;

  assign addr_ok = ({1'b0, addr_q} < DEPTH_V);
  assign load_ok = ({1'b0, load_addr} < DEPTH_V);
  assign commit  = (state == BUSY) && (enable_M != 2'b00) && (cnt == '0);
  assign busy    = (state != IDLE);

  // Single array write port shared by the core commit and the side-load; they never coincide
  // because loads are only honoured in IDLE and commits only happen in BUSY.
  always_comb begin
    mem_we   = 1'b0;
    mem_idx  = load_addr[IDX_W-1:0];
    mem_wdat = load_data;
    if (!reset) begin
      if (commit && op_wr && addr_ok) begin
        mem_we   = 1'b1;
        mem_idx  = addr_q[IDX_W-1:0];
        mem_wdat = data_q;
      end else if ((state == IDLE) && (enable_M == 2'b00) && load_en && load_ok) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= mem_wdat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      op_wr     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      ready_M   <= 1'b0;
      rd_data_M <= '0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (enable_M == 2'b11) begin
            err <= 1'b1;
          end else if (enable_M != 2'b00) begin
            op_wr  <= enable_M[1];
            addr_q <= addr_M;
            data_q <= wr_data_M;
            cnt    <= CNT_INIT;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (enable_M == 2'b00) begin
            state <= IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            ready_M <= 1'b1;
            err     <= !addr_ok;
            state   <= DONE;
            if (!op_wr) rd_data_M <= addr_ok ? mem[addr_q[IDX_W-1:0]] : '0;
          end
        end
        DONE: begin
          // Hold the completion until the core drops its request, so each request completes once.
          if (enable_M == 2'b00) begin
            ready_M <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
